// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with blanking gap, double-buffered digits and frame pulse.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN suppresses leading zeros on digits 3..1.
module seg7_scan_ctrl #(
    parameter int unsigned DIV       = 16,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [15:0] C_DIV_LAST   = 16'(DIV - 1);
    localparam logic [15:0] C_BLANK_LAST = 16'(BLANK_CYC - 1);
    localparam logic        C_HAS_BLANK  = (BLANK_CYC != 0);

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] res;
        case (bcd)
            4'd0:    res = 7'b1111110;
            4'd1:    res = 7'b0110000;
            4'd2:    res = 7'b1101101;
            4'd3:    res = 7'b1111001;
            4'd4:    res = 7'b0110011;
            4'd5:    res = 7'b1011011;
            4'd6:    res = 7'b1011111;
            4'd7:    res = 7'b1110000;
            4'd8:    res = 7'b1111111;
            4'd9:    res = 7'b1111011;
            default: res = 7'b0000000;
        endcase
        return res;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [1:0]  r_idx;
    logic [1:0]  w_idx_nxt;
    logic        w_apply;
    logic        w_frame_end;

    logic [15:0] r_active;
    logic [15:0] r_pend_val;
    logic        r_pend_flag;
    logic [15:0] w_pend_val;
    logic        w_pend_flag;
    logic        w_take_pend;
    logic [15:0] w_active_nxt;

    logic [3:0]  w_digit;
    logic        w_lz_blank;
    logic [3:0]  w_an_nxt;
    logic [6:0]  w_seg_nxt;

    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_frame_done;

    // Scan sequencing: slot counter runs 0..DIV-1, the first BLANK_CYC counts are the anode-off gap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_apply     = 1'b0;
        w_frame_end = 1'b0;
        if (!en) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 16'd0;
            w_idx_nxt   = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = C_HAS_BLANK ? ST_BLANK : ST_SHOW;
                    w_cnt_nxt   = 16'd0;
                    w_idx_nxt   = 2'd0;
                    w_apply     = 1'b1;
                end
                ST_BLANK: begin
                    w_cnt_nxt = r_cnt + 16'd1;
                    if (r_cnt == C_BLANK_LAST) begin
                        w_state_nxt = ST_SHOW;
                    end else begin
                        w_state_nxt = ST_BLANK;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == C_DIV_LAST) begin
                        w_cnt_nxt   = 16'd0;
                        w_idx_nxt   = r_idx + 2'd1;
                        w_state_nxt = C_HAS_BLANK ? ST_BLANK : ST_SHOW;
                        if (r_idx == 2'd3) begin
                            w_apply     = 1'b1;
                            w_frame_end = 1'b1;
                        end else begin
                            w_apply     = 1'b0;
                            w_frame_end = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 16'd0;
                    w_idx_nxt   = 2'd0;
                end
            endcase
        end
    end

    // A load in the same cycle as an apply point is folded in, so the newest value wins.
    always_comb begin
        w_pend_val   = load ? value : r_pend_val;
        w_pend_flag  = load | r_pend_flag;
        w_take_pend  = w_apply & w_pend_flag;
        w_active_nxt = w_take_pend ? w_pend_val : r_active;
    end

    // Digit select plus optional leading-zero suppression, evaluated on the upcoming slot.
    always_comb begin
        w_digit    = 4'd0;
        w_lz_blank = 1'b0;
        case (w_idx_nxt)
            2'd0:    w_digit = w_active_nxt[3:0];
            2'd1:    w_digit = w_active_nxt[7:4];
            2'd2:    w_digit = w_active_nxt[11:8];
            2'd3:    w_digit = w_active_nxt[15:12];
            default: w_digit = 4'd0;
        endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        case (w_idx_nxt)
            2'd3:    w_lz_blank = (w_active_nxt[15:12] == 4'd0);
            2'd2:    w_lz_blank = (w_active_nxt[15:8] == 8'd0);
            2'd1:    w_lz_blank = (w_active_nxt[15:4] == 12'd0);
            default: w_lz_blank = 1'b0;
        endcase
`else
        w_lz_blank = 1'b0;
`endif
    end

    // Output drive computed from the next state so the pins change on the same edge as the FSM.
    always_comb begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = 7'b0000000;
        if (w_state_nxt == ST_SHOW) begin
            w_an_nxt  = ~(4'b0001 << w_idx_nxt);
            w_seg_nxt = w_lz_blank ? 7'b0000000 : seg_decode(w_digit);
        end else begin
            w_an_nxt  = 4'b1111;
            w_seg_nxt = 7'b0000000;
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 16'd0;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Pending and active digit buffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active    <= 16'd0;
            r_pend_val  <= 16'd0;
            r_pend_flag <= 1'b0;
        end else begin
            r_active    <= w_active_nxt;
            r_pend_val  <= w_pend_val;
            r_pend_flag <= w_take_pend ? 1'b0 : w_pend_flag;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an         <= 4'b1111;
            r_seg        <= 7'b0000000;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_frame_done <= w_frame_end;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a cycle-position model predicts each cycle's outputs,
// a monitor pops and compares. Honours SEG7_LEADING_ZERO_BLANK_EN like the design.
module tb_seg7_scan_ctrl;

    localparam int DIV_P   = 8;
    localparam int BLANK_P = 2;
    localparam int FRAME   = 4 * DIV_P;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        load  = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    seg7_scan_ctrl #(.DIV(DIV_P), .BLANK_CYC(BLANK_P)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
        .an(an), .seg(seg), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
        logic [3:0] tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [6:0] seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
                                 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

    // Reference state: position in cycles since the scan started, plus the two digit buffers.
    bit          m_scan = 1'b0;
    int          m_pos  = 0;
    logic [15:0] m_frame = 16'h0;
    logic [15:0] m_pend  = 16'h0;
    bit          m_flag  = 1'b0;

    function automatic string tag_name(input logic [3:0] t);
        case (t)
            4'd0:    return "reset";
            4'd1:    return "idle";
            4'd2:    return "scan_1234";
            4'd3:    return "load_5678_midframe";
            4'd4:    return "digits_00A9";
            4'd5:    return "en_abort";
            4'd6:    return "async_reset";
            4'd7:    return "after_reset";
            4'd8:    return "multi_load_boundary";
            4'd9:    return "random";
            default: return "other";
        endcase
    endfunction

    task automatic model_reset();
        m_scan  = 1'b0;
        m_pos   = 0;
        m_frame = 16'h0;
        m_pend  = 16'h0;
        m_flag  = 1'b0;
    endtask

    task automatic take_pending();
        if (m_flag) begin
            m_frame = m_pend;
            m_flag  = 1'b0;
        end
    endtask

    // Apply one cycle of inputs and queue the outputs expected after the following rising edge.
    task automatic drive(input logic r, input logic e, input logic l, input logic [15:0] v,
                         input logic [3:0] tag);
        exp_t x;
        int   idx;
        int   phase;
        int   dig;
        @(negedge clk);
        rst_n = r;
        en    = e;
        load  = l;
        value = v;
        x = '{an: 4'hF, seg: 7'h00, fd: 1'b0, tag: tag};
        if (!r) begin
            model_reset();
        end else begin
            if (l) begin
                m_pend = v;
                m_flag = 1'b1;
            end
            if (!e) begin
                m_scan = 1'b0;
                m_pos  = 0;
            end else begin
                if (!m_scan) begin
                    m_scan = 1'b1;
                    m_pos  = 0;
                    take_pending();
                end else begin
                    m_pos++;
                    if (m_pos % FRAME == 0) begin
                        x.fd = 1'b1;
                        take_pending();
                    end
                end
                idx   = (m_pos / DIV_P) % 4;
                phase = m_pos % DIV_P;
                if (phase >= BLANK_P) begin
                    x.an  = 4'hF ^ (4'h1 << idx);
                    dig   = int'((m_frame >> (4 * idx)) & 16'hF);
                    x.seg = seg_tab[dig];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                    if (idx != 0 && (m_frame >> (4 * idx)) == 16'h0) x.seg = 7'h00;
`endif
                end
            end
        end
        sb_q.push_back(x);
    endtask

    task automatic run(input int n, input logic [3:0] tag);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 16'($urandom), tag);
    endtask

    task automatic run_until_slot(input int idx, input int phase, input logic [3:0] tag);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_scan && ((m_pos / DIV_P) % 4 == idx) && (m_pos % DIV_P == phase)) break;
            drive(1'b1, 1'b1, 1'b0, 16'($urandom), tag);
        end
    endtask

    // Monitor: compare every presented output sample against the queued prediction.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                n_cmp++;
                if ({an, seg, frame_done} !== {x.an, x.seg, x.fd}) begin
                    n_err++;
                    $display("FAIL %s t=%0t: got an=%b seg=%b fd=%b, expected an=%b seg=%b fd=%b",
                             tag_name(x.tag), $time, an, seg, frame_done, x.an, x.seg, x.fd);
                end
            end
        end
    end

    initial begin
        exp_t x;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 16'h0, 4'd0);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 16'($urandom), 4'd1);
        drive(1'b1, 1'b0, 1'b1, 16'h1234, 4'd1);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 16'($urandom), 4'd1);
        run(2 * FRAME + 3, 4'd2);

        run_until_slot(1, 3, 4'd3);
        drive(1'b1, 1'b1, 1'b1, 16'h5678, 4'd3);
        run(2 * FRAME, 4'd3);

        drive(1'b1, 1'b1, 1'b1, 16'h00A9, 4'd4);
        run(2 * FRAME, 4'd4);

        run_until_slot(2, BLANK_P + 2, 4'd5);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 16'($urandom), 4'd5);
        run(FRAME + 4, 4'd5);

        drive(1'b1, 1'b1, 1'b1, 16'h9999, 4'd6);
        run_until_slot(1, BLANK_P + 2, 4'd6);
        @(posedge clk);
        #2;
        x = '{an: 4'hF, seg: 7'h00, fd: 1'b0, tag: 4'd6};
        sb_q.push_back(x);
        model_reset();
        rst_n = 1'b0;
        repeat (2) drive(1'b0, 1'b1, 1'b0, 16'($urandom), 4'd6);
        run(FRAME + 4, 4'd7);

        run_until_slot(2, 1, 4'd8);
        drive(1'b1, 1'b1, 1'b1, 16'h1111, 4'd8);
        run(2, 4'd8);
        drive(1'b1, 1'b1, 1'b1, 16'h2222, 4'd8);
        for (int i = 0; i < FRAME && ((m_pos + 1) % FRAME != 0); i++) run(1, 4'd8);
        drive(1'b1, 1'b1, 1'b1, 16'h3333, 4'd8);
        run(FRAME + 2, 4'd8);

        for (int i = 0; i < 500; i++) begin
            logic        e;
            logic        l;
            logic [15:0] v;
            e = ($urandom_range(0, 24) != 0);
            l = ($urandom_range(0, 9) == 0);
            v = ($urandom_range(0, 2) == 0) ? (16'($urandom) & 16'h00FF) : 16'($urandom);
            drive(1'b1, e, l, v, 4'd9);
        end

        @(posedge clk);
        #3;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d unchecked predictions, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
